// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared types and constants for the first_nios2_system sysid reader.
package first_nios2_system_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1457698467;
  localparam int unsigned TIMEOUT_W           = 16;

endpackage

// File: rtl/first_nios2_system_sysid_timeout.sv
// Waitrequest cycle counter for one Avalon read; expired fires on the cycle that
// completes the LIMIT-th consecutive stalled cycle.
module first_nios2_system_sysid_timeout
  import first_nios2_system_sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] Last = TIMEOUT_W'(LIMIT - 1);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == Last);

endmodule

// File: rtl/first_nios2_system_sysid_reader.sv
// Reads the sysid ID and timestamp words back-to-back and compares them with the expected
// values. Define SYSID_READER_RETRY_EN to reissue a timed-out read once before giving up.
module first_nios2_system_sysid_reader
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

`ifdef SYSID_READER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        idOk_q, idOk_d;
  logic        tsOk_q, tsOk_d;
  logic        timeout_q, timeout_d;
  logic [31:0] idValue_q, idValue_d;
  logic [31:0] tsValue_q, tsValue_d;
  logic        gap_q, gap_d;
  logic        retried_q, retried_d;

  logic reading;
  logic stalled;
  logic accept;
  logic expired;

  // gap_q marks the single idle cycle between a timed-out read and its retry
  assign reading = ((state_q == RD_ID) || (state_q == RD_TS)) && !gap_q;
  assign stalled = reading && avm_waitrequest;
  assign accept  = reading && !avm_waitrequest;

  first_nios2_system_sysid_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (!stalled),
    .enable (stalled),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    idOk_d    = idOk_q;
    tsOk_d    = tsOk_q;
    timeout_d = timeout_q;
    idValue_d = idValue_q;
    tsValue_d = tsValue_q;
    gap_d     = 1'b0;
    retried_d = retried_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_ID;
          idOk_d    = 1'b0;
          tsOk_d    = 1'b0;
          timeout_d = 1'b0;
          retried_d = 1'b0;
        end
      end
      RD_ID: begin
        if (accept) begin
          idValue_d = avm_readdata;
          idOk_d    = (avm_readdata == EXPECTED_ID);
          retried_d = 1'b0;
          state_d   = RD_TS;
        end else if (expired) begin
          if (RetryEn && !retried_q) begin
            gap_d     = 1'b1;
            retried_d = 1'b1;
          end else begin
            timeout_d = 1'b1;
            state_d   = FINISH;
          end
        end
      end
      RD_TS: begin
        if (accept) begin
          tsValue_d = avm_readdata;
          tsOk_d    = (avm_readdata == EXPECTED_TS);
          retried_d = 1'b0;
          state_d   = FINISH;
        end else if (expired) begin
          if (RetryEn && !retried_q) begin
            gap_d     = 1'b1;
            retried_d = 1'b1;
          end else begin
            timeout_d = 1'b1;
            state_d   = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idOk_q    <= 1'b0;
      tsOk_q    <= 1'b0;
      timeout_q <= 1'b0;
      idValue_q <= '0;
      tsValue_q <= '0;
      gap_q     <= 1'b0;
      retried_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idOk_q    <= idOk_d;
      tsOk_q    <= tsOk_d;
      timeout_q <= timeout_d;
      idValue_q <= idValue_d;
      tsValue_q <= tsValue_d;
      gap_q     <= gap_d;
      retried_q <= retried_d;
    end
  end

  assign avm_read    = reading;
  assign avm_address = (state_q == RD_TS);
  assign busy        = (state_q == RD_ID) || (state_q == RD_TS);
  assign done        = (state_q == FINISH);
  assign id_ok       = idOk_q;
  assign ts_ok       = tsOk_q;
  assign timeout     = timeout_q;
  assign id_value    = idValue_q;
  assign ts_value    = tsValue_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_reader.sv
// Scoreboard bench for the sysid reader: a wait-state responder, a per-check reference model
// and a done-driven monitor. Honours SYSID_READER_RETRY_EN like the design.
module tb_first_nios2_system_sysid_reader;

  localparam int          T      = 4;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1457698467;
`ifdef SYSID_READER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct {
    int          doneCyc;
    bit          idOk;
    bit          tsOk;
    bit          tmo;
    logic [31:0] idVal;
    logic [31:0] tsVal;
    bit          tsRead;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        expQ[$];
  exp_t        monE;

  int          cfgWaitId, cfgWaitTs, givenId, givenTs;
  logic [31:0] cfgIdData, cfgTsData;
  logic [31:0] lastId = '0;
  logic [31:0] lastTs = '0;
  bit          sawAddr1;
  bit          pendChk = 1'b0;
  logic        pendAddr;

  first_nios2_system_sysid_reader #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Outcome of one read that the slave stalls for w cycles in total
  function automatic void modelRead(input int w, output bit ok, output int cycles);
    if (w < T) begin
      ok = 1'b1;
      cycles = w + 1;
    end else if (RETRY && (w - T) < T) begin
      ok = 1'b1;
      cycles = T + 1 + (w - T) + 1;
    end else begin
      ok = 1'b0;
      cycles = RETRY ? (2 * T + 1) : T;
    end
  endfunction

  // Slave: stalls each address for its programmed number of strobed cycles, then returns data
  always @(negedge clock) begin
    if (pendChk && avm_read) checkOutput("addrStable", {31'd0, avm_address}, {31'd0, pendAddr});
    pendChk = 1'b0;
    if (avm_read) begin
      if (avm_address) sawAddr1 = 1'b1;
      if (!avm_address && givenId < cfgWaitId) begin
        givenId++;
        avm_waitrequest = 1'b1;
        avm_readdata = $urandom;
      end else if (avm_address && givenTs < cfgWaitTs) begin
        givenTs++;
        avm_waitrequest = 1'b1;
        avm_readdata = $urandom;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = avm_address ? cfgTsData : cfgIdData;
      end
      if (avm_waitrequest) begin
        pendChk = 1'b1;
        pendAddr = avm_address;
      end
    end else begin
      avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata = $urandom;
    end
  end

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", 32'd1, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("doneCycle", 32'(cyc), 32'(monE.doneCyc));
        checkOutput("id_ok", {31'd0, id_ok}, {31'd0, monE.idOk});
        checkOutput("ts_ok", {31'd0, ts_ok}, {31'd0, monE.tsOk});
        checkOutput("timeout", {31'd0, timeout}, {31'd0, monE.tmo});
        checkOutput("id_value", id_value, monE.idVal);
        checkOutput("ts_value", ts_value, monE.tsVal);
        checkOutput("tsReadIssued", {31'd0, sawAddr1}, {31'd0, monE.tsRead});
        checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
        checkOutput("readAtDone", {31'd0, avm_read}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input int wId, input int wTs, input logic [31:0] dId,
                               input logic [31:0] dTs);
    exp_t e;
    bit   idAcc, tsAcc;
    int   idCyc, tsCyc;
    @(negedge clock);
    cfgWaitId = wId;
    cfgWaitTs = wTs;
    cfgIdData = dId;
    cfgTsData = dTs;
    givenId = 0;
    givenTs = 0;
    sawAddr1 = 1'b0;
    modelRead(wId, idAcc, idCyc);
    tsAcc = 1'b0;
    tsCyc = 0;
    if (idAcc) modelRead(wTs, tsAcc, tsCyc);
    if (idAcc) lastId = dId;
    if (tsAcc) lastTs = dTs;
    e.doneCyc = cyc + 1 + idCyc + tsCyc;
    e.idOk    = idAcc && (dId == EXP_ID);
    e.tsOk    = tsAcc && (dTs == EXP_TS);
    e.tmo     = !idAcc || !tsAcc;
    e.idVal   = lastId;
    e.tsVal   = lastTs;
    e.tsRead  = idAcc;
    expQ.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("doneWithinBudget", 32'd0, 32'd1);
      expQ.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
    checkOutput({tag, "_avm_address"}, {31'd0, avm_address}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_id_ok"}, {31'd0, id_ok}, 32'd0);
    checkOutput({tag, "_ts_ok"}, {31'd0, ts_ok}, 32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    checkOutput({tag, "_id_value"}, id_value, 32'd0);
    checkOutput({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    int n;
    int wMax;
    cfgWaitId = 0;
    cfgWaitTs = 0;
    givenId = 0;
    givenTs = 0;
    cfgIdData = '0;
    cfgTsData = '0;
    sawAddr1 = 1'b0;
    #1 reset_n = 1'b0;
    #2 checkAllZero("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] pass, mismatch and wait-state checks");
    applyStimulus(0, 0, EXP_ID, EXP_TS);
    waitDone();
    applyStimulus(0, 0, EXP_ID, 32'h12345678);
    waitDone();
    applyStimulus(3, 3, EXP_ID, EXP_TS);
    waitDone();

    $display("[TB] stuck waitrequest");
    applyStimulus(1000, 0, EXP_ID, EXP_TS);
    waitDone();

    $display("[TB] start while busy");
    applyStimulus(3, 1, 32'h0000_00aa, EXP_TS);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone();
    repeat (5) @(negedge clock);

    $display("[TB] reset during timestamp read");
    applyStimulus(0, 5, EXP_ID, EXP_TS);
    n = 0;
    while (!(avm_read && avm_address) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("reachedTsRead", {31'd0, avm_read && avm_address}, 32'd1);
    #2 reset_n = 1'b0;
    #1 checkAllZero("midReset");
    expQ.delete();
    lastId = '0;
    lastTs = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    checkAllZero("afterRelease");

    $display("[TB] randomized checks");
    wMax = RETRY ? (2 * T + 1) : (T + 1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(0, wMax)), int'($urandom_range(0, wMax)),
                    ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom,
                    ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom);
      waitDone();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
